// File: rtl/spi_ram_pkg.sv
// Shared constants, FSM state type and frame geometry for the SPI RAM initiator.
package spi_ram_pkg;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_WRITE     = 8'h02;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;

  // Standard frame: cmd + 24-bit address + 16-bit data; fast read adds 8 dummy bits.
  localparam int FRAME_LEN      = 48;
  localparam int FAST_FRAME_LEN = 56;
  localparam int FRAME_W        = FAST_FRAME_LEN;
  localparam int CNT_W          = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/spi_ram_initiator_spi_clk_gen.sv
// SPI clock divider: spi_clk idles low while disabled; rise/fall strobe in the
// clk cycle before spi_clk changes level, so consumers act on the same edge.
module spi_clk_gen #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic spi_clk,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(CLK_DIV + 1);

  logic [CW-1:0] cnt;
  logic          last;

  assign last = (cnt == CW'(CLK_DIV - 1));
  assign rise = en & last & ~spi_clk;
  assign fall = en & last & spi_clk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      spi_clk <= 1'b0;
    end else if (!en) begin
      cnt     <= '0;
      spi_clk <= 1'b0;
    end else if (last) begin
      cnt     <= '0;
      spi_clk <= ~spi_clk;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_ram_initiator.sv
// SPI mode-0 initiator for 16-bit word reads/writes to a 23LC-style serial SRAM.
// Define SPI_RAM_FAST_READ_EN to issue reads as 0x0B with 8 dummy bits.
// Handshake: start is taken only in IDLE (busy=0); done pulses once per accepted start.
module spi_ram_initiator
  import spi_ram_pkg::*;
#(
  parameter int CLK_DIV = 1,
  parameter int ADDR_W  = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata,
  output logic              busy,
  output logic              done,
  output logic              spi_select,
  output logic              spi_clk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  state_t             state, state_nxt;
  logic [FRAME_W-1:0] frame, frame_init;
  logic [CNT_W-1:0]   bit_cnt, cnt_init;
  logic [15:0]        rx;
  logic [23:0]        addr24;
  logic               is_write;
  logic               rise, fall;

  assign addr24 = 24'(addr);

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (state == SHIFT),
    .spi_clk (spi_clk),
    .rise    (rise),
    .fall    (fall)
  );

  // Frame is right-aligned; bit_cnt indexes the bit currently on the wire.
  always_comb begin
    frame_init = '0;
    cnt_init   = CNT_W'(FRAME_LEN - 1);
    if (write) begin
      frame_init = FRAME_W'({CMD_WRITE, addr24, wdata});
    end else begin
`ifdef SPI_RAM_FAST_READ_EN
      frame_init = {CMD_FAST_READ, addr24, 8'h00, 16'h0000};
      cnt_init   = CNT_W'(FAST_FRAME_LEN - 1);
`else
      frame_init = FRAME_W'({CMD_READ, addr24, 16'h0000});
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (fall && bit_cnt == '0) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame      <= '0;
      bit_cnt    <= '0;
      is_write   <= 1'b0;
      rx         <= '0;
      rdata      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      spi_select <= 1'b1;
      spi_mosi   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            frame      <= frame_init;
            bit_cnt    <= cnt_init;
            is_write   <= write;
            busy       <= 1'b1;
            spi_select <= 1'b0;
            spi_mosi   <= frame_init[cnt_init];
          end
        end
        SHIFT: begin
          if (rise) rx <= {rx[14:0], spi_miso};
          // mosi only moves on the falling spi_clk edge (mode 0)
          if (fall) begin
            if (bit_cnt == '0) begin
              spi_select <= 1'b1;
              spi_mosi   <= 1'b0;
            end else begin
              bit_cnt  <= bit_cnt - 1'b1;
              spi_mosi <= frame[bit_cnt - 1'b1];
            end
          end
        end
        FINISH: begin
          done <= 1'b1;
          busy <= 1'b0;
          if (!is_write) rdata <= rx;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ram_initiator.sv
// Bench for spi_ram_initiator: two instances (CLK_DIV=1 and 2) share a
// behavioural 23LC-style responder selected by 'sel'.
module tb_spi_ram_initiator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, write, sel, miso;
  logic [23:0] addr;
  logic [15:0] wdata;
  logic        start1, start2;
  logic [15:0] rdata1, rdata2;
  logic        busy1, busy2, done1, done2, cs1, cs2, sck1, sck2, mo1, mo2;

  assign start1 = start & ~sel;
  assign start2 = start & sel;

  spi_ram_initiator #(.CLK_DIV(1), .ADDR_W(24)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .write(write), .addr(addr),
    .wdata(wdata), .rdata(rdata1), .busy(busy1), .done(done1),
    .spi_select(cs1), .spi_clk(sck1), .spi_mosi(mo1), .spi_miso(miso)
  );

  spi_ram_initiator #(.CLK_DIV(2), .ADDR_W(24)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .write(write), .addr(addr),
    .wdata(wdata), .rdata(rdata2), .busy(busy2), .done(done2),
    .spi_select(cs2), .spi_clk(sck2), .spi_mosi(mo2), .spi_miso(miso)
  );

  logic [15:0] s_rdata;
  logic        s_busy, s_done, s_sel, s_clk, s_mosi;
  assign s_rdata = sel ? rdata2 : rdata1;
  assign s_busy  = sel ? busy2  : busy1;
  assign s_done  = sel ? done2  : done1;
  assign s_sel   = sel ? cs2    : cs1;
  assign s_clk   = sel ? sck2   : sck1;
  assign s_mosi  = sel ? mo2    : mo1;

  // ---------------- responder model ----------------
  logic [7:0]  mem [0:255];
  logic [63:0] fr;
  int          n_rise;
  logic [7:0]  r_cmd, r_ai, w_ai;
  logic [15:0] r_word;

  always @(negedge s_sel) begin
    fr = '0; n_rise = 0; r_cmd = '0;
  end

  always @(posedge s_clk) begin
    if (!s_sel) begin
      fr = {fr[62:0], s_mosi};
      n_rise++;
      if (n_rise == 8) r_cmd = fr[7:0];
      if (n_rise == 32) begin
        r_ai   = fr[7:0];
        r_word = {mem[r_ai], mem[r_ai + 8'd1]};
      end
      if (n_rise == 48 && r_cmd == 8'h02) begin
        w_ai = fr[23:16];
        mem[w_ai]        = fr[15:8];
        mem[w_ai + 8'd1] = fr[7:0];
      end
    end
  end

  always @(negedge s_clk or posedge s_sel) begin
    int ds;
    miso = 1'b0;
    if (!s_sel && (r_cmd == 8'h03 || r_cmd == 8'h0B)) begin
      ds = (r_cmd == 8'h0B) ? 40 : 32;
      if (n_rise >= ds && n_rise < ds + 16) miso = r_word[15 - (n_rise - ds)];
    end
  end

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  logic [15:0] last_rd1, last_rd2;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_txn(input logic wr, input logic [23:0] a, input logic [15:0] d,
                        input int pulse_at, input string tag);
    int          div, exp_cyc, exp_bits, cyc, done_cyc, n_done;
    logic [63:0] exp_fr;
    logic [15:0] e, prev_rd;
    logic [7:0]  ai;
    ai      = a[7:0];
    div     = sel ? 2 : 1;
    prev_rd = sel ? last_rd2 : last_rd1;
    if (wr) begin
      exp_bits = 48;
      exp_fr   = {16'h0, 8'h02, a, d};
      exp_q.push_back(d);
    end else begin
`ifdef SPI_RAM_FAST_READ_EN
      exp_bits = 56;
      exp_fr   = {8'h0, 8'h0B, a, 24'h0};
`else
      exp_bits = 48;
      exp_fr   = {16'h0, 8'h03, a, 16'h0};
`endif
      exp_q.push_back({mem[ai], mem[ai + 8'd1]});
    end
    exp_cyc = 1 + 2 * exp_bits * div;

    @(negedge clk);
    start = 1'b1; write = wr; addr = a; wdata = d;
    cyc = 0; done_cyc = -1; n_done = 0;
    @(posedge clk);
    while (cyc <= exp_cyc + 4) begin
      @(negedge clk);
      if (cyc == 0) begin
        start = 1'b0;
        chk({tag, "_busy_start"}, 64'(s_busy), 64'd1);
        chk({tag, "_select_low"}, 64'(s_sel), 64'd0);
      end
      if (cyc == pulse_at) begin
        start = 1'b1; wdata = ~d; addr = ~a;
      end else if (cyc == pulse_at + 1) begin
        start = 1'b0; wdata = d; addr = a;
      end
      if (s_done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (cyc == exp_cyc) begin
        chk({tag, "_busy_done"}, 64'(s_busy), 64'd0);
        chk({tag, "_select_done"}, 64'(s_sel), 64'd1);
      end
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    chk({tag, "_done_count"}, 64'(n_done), 64'd1);
    chk({tag, "_done_cycle"}, 64'(done_cyc), 64'(exp_cyc));
    chk({tag, "_sck_rises"}, 64'(n_rise), 64'(exp_bits));
    chk({tag, "_mosi_frame"}, fr, exp_fr);
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd1);
    end else begin
      e = exp_q.pop_front();
      if (wr) begin
        chk({tag, "_ram_word"}, 64'({mem[ai], mem[ai + 8'd1]}), 64'(e));
        chk({tag, "_rdata_kept"}, 64'(s_rdata), 64'(prev_rd));
      end else begin
        chk({tag, "_rdata"}, 64'(s_rdata), 64'(e));
        if (sel) last_rd2 = e;
        else     last_rd1 = e;
      end
    end
  endtask

  initial begin
    int          n_done;
    logic [23:0] ra;
    logic [15:0] rd;
    rst_n = 1'b0; start = 1'b0; write = 1'b0; addr = '0; wdata = '0; sel = 1'b0;
    last_rd1 = '0; last_rd2 = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_select", 64'({cs1, cs2}), 64'b11);
    chk("rst_sck", 64'({sck1, sck2}), 64'b00);
    chk("rst_busy", 64'({busy1, busy2}), 64'b00);
    chk("rst_done", 64'({done1, done2}), 64'b00);
    chk("rst_mosi", 64'({mo1, mo2}), 64'b00);
    chk("rst_rdata", 64'({rdata1, rdata2}), 64'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    sel = 1'b0;
    do_txn(1'b1, 24'h000010, 16'hBEEF, -1, "wr_div1");
    chk("wr_div1_byte10", 64'(mem[8'h10]), 64'hBE);

    mem[8'h20] = 8'h12; mem[8'h21] = 8'h34;
    sel = 1'b1;
    do_txn(1'b0, 24'h000020, 16'h0000, -1, "rd_div2");

    sel = 1'b0;
    do_txn(1'b1, 24'h000040, 16'hA55A, 10, "wr_busy_pulse");
    do_txn(1'b0, 24'h000040, 16'h0000, 10, "rd_busy_pulse");

    for (int i = 0; i < 3; i++) begin
      ra = 24'($urandom_range(0, 127)) * 24'd2;
      rd = 16'($urandom_range(0, 65535));
      sel = 1'b1;
      do_txn(1'b1, ra, rd, -1, "wr_rand");
      sel = 1'b0;
      do_txn(1'b0, ra, 16'h0000, -1, "rd_rand");
    end

    // reset in the middle of a read on the CLK_DIV=1 instance
    sel = 1'b0;
    mem[8'h20] = 8'h12; mem[8'h21] = 8'h34;
    @(negedge clk);
    start = 1'b1; write = 1'b0; addr = 24'h000020;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_select", 64'(cs1), 64'd1);
    chk("midrst_sck", 64'(sck1), 64'd0);
    chk("midrst_busy", 64'(busy1), 64'd0);
    chk("midrst_mosi", 64'(mo1), 64'd0);
    last_rd1 = '0;
    n_done = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (done1) n_done++;
    end
    chk("midrst_no_done", 64'(n_done), 64'd0);
    do_txn(1'b0, 24'h000020, 16'h0000, -1, "rd_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
